// File: rtl/combine_iq_stream.sv
// -----------------------------------------------------------------------------
// combine_iq_stream
//
// Transmit-side IQ join. Two independent AXI-Stream sample channels (I and Q)
// each go through a small FIFO. When both FIFOs hold a sample and the output
// register is free or being drained, one sample is popped from each. Each
// sample is left-shifted by MSB_EXTEND_BITS, saturated to O_WIDTH/2 bits, and
// the pair is packed as {I_ext, Q_ext} into a registered output.
//
// Ports
//   clk         in   1          system clock, rising edge
//   rst_n       in   1          asynchronous active-low reset
//   I_tdata     in   I_WIDTH    signed I sample
//   I_tvalid    in   1          I sample valid
//   I_tready    out  1          I FIFO can accept
//   Q_tdata     in   I_WIDTH    signed Q sample
//   Q_tvalid    in   1          Q sample valid
//   Q_tready    out  1          Q FIFO can accept
//   IQ_tdata    out  O_WIDTH    packed {I_ext, Q_ext}, I in the upper half
//   IQ_tvalid   out  1          packed sample valid
//   IQ_tready   in   1          downstream accepts
//   sat_flag    out  1          sticky: a saturated sample was loaded
//   sat_clr     in   1          synchronous clear of sat_flag (set wins)
// -----------------------------------------------------------------------------
module combine_iq_stream #(
    parameter int I_WIDTH         = 16,
    parameter int O_WIDTH         = 48,
    parameter int MSB_EXTEND_BITS = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [I_WIDTH-1:0]   I_tdata,
    input  logic                 I_tvalid,
    output logic                 I_tready,
    input  logic [I_WIDTH-1:0]   Q_tdata,
    input  logic                 Q_tvalid,
    output logic                 Q_tready,
    output logic [O_WIDTH-1:0]   IQ_tdata,
    output logic                 IQ_tvalid,
    input  logic                 IQ_tready,
    output logic                 sat_flag,
    input  logic                 sat_clr
);

    // Width of one packed half and of the intermediate shifted value.
    localparam int H     = O_WIDTH / 2;
    localparam int XW    = H + MSB_EXTEND_BITS;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Channel index 1 = I (upper half), 0 = Q (lower half).
    logic [1:0][I_WIDTH-1:0] ch_tdata;
    logic [1:0]              ch_tvalid;
    logic [1:0]              ch_tready;
    logic [1:0]              ch_empty;
    logic [1:0]              ch_sat;
    logic [1:0][H-1:0]       ch_ext;

    logic                    pop;

    // Holds tready low while in reset and for nothing else; goes high on the
    // first clock edge after rst_n is released.
    logic                    ready_en_q, ready_en_d;

    logic                    out_valid_q, out_valid_d;
    logic [O_WIDTH-1:0]      out_data_q, out_data_d;
    logic                    sat_flag_q, sat_flag_d;

    assign ch_tdata[1]  = I_tdata;
    assign ch_tdata[0]  = Q_tdata;
    assign ch_tvalid[1] = I_tvalid;
    assign ch_tvalid[0] = Q_tvalid;
    assign I_tready     = ch_tready[1];
    assign Q_tready     = ch_tready[0];

    // Pairing: both channels must have data, and the output register must be
    // empty or emptying this cycle. One channel is never popped alone.
    assign pop = !ch_empty[1] && !ch_empty[0] && (!out_valid_q || IQ_tready);

    // -------------------------------------------------------------------------
    // Per-channel FIFO + shift/saturate
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            // Pointers carry one extra wrap bit so full and empty are
            // distinguishable without a separate counter.
            logic [PTR_W:0]             wr_ptr_q, wr_ptr_d;
            logic [PTR_W:0]             rd_ptr_q, rd_ptr_d;
            logic [I_WIDTH-1:0]         mem [FIFO_DEPTH];
            logic                       full;
            logic                       push;
            logic signed [I_WIDTH-1:0]  head;
            logic signed [XW-1:0]       shifted;
            logic [XW-H:0]              top_bits;
            logic                       overflow;
            logic [H-1:0]               sat_value;

            assign full = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                          (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
            assign ch_empty[gi]  = (wr_ptr_q == rd_ptr_q);
            assign ch_tready[gi] = ready_en_q && !full;
            assign push          = ch_tvalid[gi] && ch_tready[gi];

            always_comb begin
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
                rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end

            // Storage is not reset; the pointers alone define what is valid.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_q[PTR_W-1:0]] <= ch_tdata[gi];
                end
            end

            // Head-of-FIFO is read combinationally so a pair can be popped the
            // cycle after it was written (two-cycle input-to-output latency).
            assign head = mem[rd_ptr_q[PTR_W-1:0]];

            // Sign-extend to H+MSB_EXTEND_BITS before shifting so no bits are
            // lost; the result fits in H bits only if every bit from the top
            // down to bit H-1 agrees with the sign.
            assign shifted  = XW'(head) <<< MSB_EXTEND_BITS;
            assign top_bits = shifted[XW-1:H-1];
            assign overflow = !((&top_bits) || !(|top_bits));

            assign sat_value = shifted[XW-1] ? {1'b1, {(H-1){1'b0}}}
                                             : {1'b0, {(H-1){1'b1}}};

            assign ch_sat[gi] = overflow;
            assign ch_ext[gi] = overflow ? sat_value : shifted[H-1:0];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output register and sticky saturation flag
    // -------------------------------------------------------------------------
    always_comb begin
        ready_en_d  = 1'b1;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sat_flag_d  = sat_flag_q && !sat_clr;

        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = {ch_ext[1], ch_ext[0]};
            // A new saturation overrides a simultaneous clear.
            if (|ch_sat) begin
                sat_flag_d = 1'b1;
            end
        end else if (IQ_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_flag_q  <= 1'b0;
        end else begin
            ready_en_q  <= ready_en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign IQ_tvalid = out_valid_q;
    assign IQ_tdata  = out_data_q;
    assign sat_flag  = sat_flag_q;

endmodule
